// File: rtl/mem_stage_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_stage_if : EX-side inputs and M/W-side outputs of the MIPS memory stage
// Revision     : 1.0
// ---------------------------------------------------------------------------
interface mem_stage_if;
   logic [31:0] ALUResE;
   logic [31:0] RegD2E;
   logic [4:0]  RegWriteAddrE;
   logic        RegWriteE;
   logic        MemtoRegE;
   logic        MemWriteE;
   logic        MemReadE;
   logic [1:0]  MemSizeE;
   logic        MemSignedE;
   logic        StallM;
   logic        FlushM;

   logic [31:0] ALUResM;
   logic [31:0] DataMemDM;
   logic [4:0]  RegWriteAddrM;
   logic        RegWriteM;
   logic        MemReadM;
   logic [31:0] RegWriteDataW;
   logic [4:0]  RegWriteAddrW;
   logic        RegWriteW;
   logic        AlignErrM;
   logic        AlignErrSticky;

   modport master (
      output ALUResE, RegD2E, RegWriteAddrE, RegWriteE, MemtoRegE, MemWriteE,
             MemReadE, MemSizeE, MemSignedE, StallM, FlushM,
      input  ALUResM, DataMemDM, RegWriteAddrM, RegWriteM, MemReadM,
             RegWriteDataW, RegWriteAddrW, RegWriteW, AlignErrM, AlignErrSticky
   );

   modport slave (
      input  ALUResE, RegD2E, RegWriteAddrE, RegWriteE, MemtoRegE, MemWriteE,
             MemReadE, MemSizeE, MemSignedE, StallM, FlushM,
      output ALUResM, DataMemDM, RegWriteAddrM, RegWriteM, MemReadM,
             RegWriteDataW, RegWriteAddrW, RegWriteW, AlignErrM, AlignErrSticky
   );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_stage : EX/MEM register, byte-lane data memory, load align/extend, MEM/WB
// Revision  : 1.0
// ---------------------------------------------------------------------------
module mem_stage #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic        clk,
   input  logic        rst,
   mem_stage_if.slave  bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef struct packed {
      logic [31:0] alu_res;
      logic [31:0] reg_d2;
      logic [4:0]  waddr;
      logic        reg_write;
      logic        mem_to_reg;
      logic        mem_write;
      logic        mem_read;
      logic [1:0]  mem_size;
      logic        mem_signed;
   } exm_t;

   exm_t        exm_d, exm_q;
   logic [31:0] wb_data_d, wb_data_q;
   logic [4:0]  wb_addr_d, wb_addr_q;
   logic        wb_we_d, wb_we_q;
   logic        sticky_d, sticky_q;

   logic [31:0] mem_q [DEPTH];

   logic [DEPTH_LOG2-1:0] word_addr;
   logic [31:0] rd_word, rd_shift, ld_data, st_data;
   logic [15:0] rd_half;
   logic [3:0]  st_be;
   logic        align_err, st_en;

   always_comb begin
      exm_d = exm_q;
      if (bus.FlushM) begin
         exm_d = '0;
      end else if (!bus.StallM) begin
         exm_d.alu_res    = bus.ALUResE;
         exm_d.reg_d2     = bus.RegD2E;
         exm_d.waddr      = bus.RegWriteAddrE;
         exm_d.reg_write  = bus.RegWriteE;
         exm_d.mem_to_reg = bus.MemtoRegE;
         exm_d.mem_write  = bus.MemWriteE;
         exm_d.mem_read   = bus.MemReadE;
         exm_d.mem_size   = bus.MemSizeE;
         exm_d.mem_signed = bus.MemSignedE;
      end
   end

   // Only real memory accesses can be misaligned; size 11 behaves as word.
   always_comb begin
      align_err = 1'b0;
      if (exm_q.mem_write || exm_q.mem_read) begin
         case (exm_q.mem_size)
            2'b00:   align_err = 1'b0;
            2'b01:   align_err = exm_q.alu_res[0];
            default: align_err = |exm_q.alu_res[1:0];
         endcase
      end
   end

   // Upper address bits are ignored, so addresses wrap over the memory depth.
   assign word_addr = exm_q.alu_res[DEPTH_LOG2+1:2];
   assign rd_word   = mem_q[word_addr];

   always_comb begin
      rd_shift = rd_word >> {exm_q.alu_res[1:0], 3'b000};
      rd_half  = exm_q.alu_res[1] ? rd_word[31:16] : rd_word[15:0];
      case (exm_q.mem_size)
         2'b00:   ld_data = {{24{exm_q.mem_signed & rd_shift[7]}}, rd_shift[7:0]};
         2'b01:   ld_data = {{16{exm_q.mem_signed & rd_half[15]}}, rd_half};
         default: ld_data = rd_word;
      endcase
      if (align_err) begin
         ld_data = 32'd0;
      end
   end

   always_comb begin
      case (exm_q.mem_size)
         2'b00: begin
            st_be   = 4'b0001 << exm_q.alu_res[1:0];
            st_data = {4{exm_q.reg_d2[7:0]}};
         end
         2'b01: begin
            st_be   = exm_q.alu_res[1] ? 4'b1100 : 4'b0011;
            st_data = {2{exm_q.reg_d2[15:0]}};
         end
         default: begin
            st_be   = 4'b1111;
            st_data = exm_q.reg_d2;
         end
      endcase
   end

   assign st_en = exm_q.mem_write & ~align_err & ~bus.StallM & ~rst;

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (st_en && st_be[i]) begin
            mem_q[word_addr][8*i +: 8] <= st_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      wb_data_d = wb_data_q;
      wb_addr_d = wb_addr_q;
      wb_we_d   = wb_we_q;
      sticky_d  = sticky_q | (align_err & ~bus.StallM);
      if (!bus.StallM) begin
         wb_data_d = exm_q.mem_to_reg ? ld_data : exm_q.alu_res;
         wb_addr_d = exm_q.waddr;
         wb_we_d   = exm_q.reg_write & ~(exm_q.mem_read & align_err);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         exm_q     <= '0;
         wb_data_q <= 32'd0;
         wb_addr_q <= 5'd0;
         wb_we_q   <= 1'b0;
         sticky_q  <= 1'b0;
      end else begin
         exm_q     <= exm_d;
         wb_data_q <= wb_data_d;
         wb_addr_q <= wb_addr_d;
         wb_we_q   <= wb_we_d;
         sticky_q  <= sticky_d;
      end
   end

   assign bus.ALUResM        = exm_q.alu_res;
   assign bus.DataMemDM      = ld_data;
   assign bus.RegWriteAddrM  = exm_q.waddr;
   assign bus.RegWriteM      = exm_q.reg_write;
   assign bus.MemReadM       = exm_q.mem_read;
   assign bus.RegWriteDataW  = wb_data_q;
   assign bus.RegWriteAddrW  = wb_addr_q;
   assign bus.RegWriteW      = wb_we_q;
   assign bus.AlignErrM      = align_err;
   assign bus.AlignErrSticky = sticky_q;
endmodule
`default_nettype wire
